// File: rtl/cs_sample_tx_if.sv
// Sample-memory read bus between cs_sample_tx and its sample RAM.
// Read data is returned exactly one cycle after the strobe.
interface cs_sample_tx_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/cs_sample_tx.sv
// Streams N samples from sample memory into the CS window filter input.
// Two-cycle read-to-X latency; tracks a 9-deep window fill for y_valid.
module cs_sample_tx #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              pause,
  cs_sample_tx_if.master    mem,
  output logic [DATA_W-1:0] X,
  output logic              x_valid,
  output logic              y_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [3:0]      WIN = 4'd9;

  state_t            r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [ADDR_W:0]   r_sent;
  logic [3:0]        r_win;
  logic              r_rd_d1;
  logic              r_xv;
  logic              r_yv;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_x;

  logic w_rd;
  logic w_last_rd;

  // Read strobe is combinational so pause gates the very cycle it is high.
  assign w_rd      = (r_state == S_RUN) && !pause;
  assign w_last_rd = w_rd && (r_rd_cnt == r_n - ONE);

  assign mem.mem_rd   = w_rd;
  assign mem.mem_addr = r_rd_cnt[ADDR_W-1:0];

  assign X        = r_x;
  assign x_valid  = r_xv;
  assign y_valid  = r_yv;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_rd_cnt <= '0;
      r_sent   <= '0;
      r_win    <= '0;
      r_rd_d1  <= 1'b0;
      r_xv     <= 1'b0;
      r_yv     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_x      <= '0;
    end else begin
      r_rd_d1 <= w_rd;
      r_xv    <= r_rd_d1;
      r_yv    <= r_xv && (r_win == WIN);
      r_done  <= 1'b0;

      // mem_data is valid now for the read issued last cycle
      if (r_rd_d1) begin
        r_x    <= mem.mem_data;
        r_sent <= r_sent + ONE;
        if (r_win != WIN) begin
          r_win <= r_win + 4'd1;
        end
      end

      if (w_rd) begin
        r_rd_cnt <= r_rd_cnt + ONE;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= num_samples;
            r_rd_cnt <= '0;
            r_sent   <= '0;
            r_win    <= '0;
            if (num_samples == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last_rd) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_sent == r_n) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_sample_tx.sv
// Bench for cs_sample_tx: directed table, corner sequences, random pause.
// Expected behaviour is derived from read-slot lists, not FSM state.
module tb_cs_sample_tx;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   num_samples;
  logic          pause;
  logic [DW-1:0] X;
  logic          x_valid;
  logic          y_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   sent_cnt;

  cs_sample_tx_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  cs_sample_tx #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_samples (num_samples),
    .pause       (pause),
    .mem         (mif),
    .X           (X),
    .x_valid     (x_valid),
    .y_valid     (y_valid),
    .busy        (busy),
    .done        (done),
    .sent_cnt    (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns addr+10 one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mif.mem_rd) mif.mem_data <= DW'(int'(mif.mem_addr) + 10);
    else            mif.mem_data <= DW'($urandom);
  end

  int checks = 0;
  int errors = 0;
  int last_x = 0;
  int prev_sent = 0;
  bit pause_pat [0:4095];

  typedef struct {
    int n;
    int p_lo;
    int p_hi;
    int exp_done;
    int exp_nx;
    int exp_ny;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, c, act, exp);
    end
  endtask

  task automatic run_xfer(input int n, input int rst_cyc, input int restart_cyc,
                          output int done_cyc, output int nx, output int ny);
    int rc[$];
    int dexp, lastc, rd_j, xv_e, yv_e, sent_e, x_e;
    rc = {};
    done_cyc = -1;
    nx = 0;
    ny = 0;
    for (int t = 1; t < 4000 && rc.size() < n; t++)
      if (!pause_pat[t]) rc.push_back(t);
    if (rc.size() < n) begin
      chk("pause_pattern_fits", 0, rc.size(), n);
      return;
    end
    dexp  = (n == 0) ? 1 : rc[n-1] + 3;
    lastc = (rst_cyc >= 0) ? rst_cyc + 3 : dexp;
    for (int c = 0; c <= lastc; c++) begin
      @(posedge clk);
      #1;
      start       = (c == 0) || (c == restart_cyc);
      num_samples = (c == 0) ? (AW+1)'(n) : (AW+1)'(3);
      pause       = pause_pat[c];
      reset       = (c == rst_cyc);
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = c;
      nx += int'(x_valid);
      ny += int'(y_valid);
      if (rst_cyc >= 0 && c > rst_cyc) begin
        chk("rst_mem_rd", c, mif.mem_rd, 0);
        chk("rst_mem_addr", c, mif.mem_addr, 0);
        chk("rst_x_valid", c, x_valid, 0);
        chk("rst_y_valid", c, y_valid, 0);
        chk("rst_busy", c, busy, 0);
        chk("rst_done", c, done, 0);
        chk("rst_X", c, X, 0);
        chk("rst_sent", c, sent_cnt, 0);
      end else begin
        rd_j = -1;
        xv_e = 0;
        yv_e = 0;
        sent_e = 0;
        foreach (rc[j]) begin
          if (rc[j] == c) rd_j = j;
          if (rc[j] + 2 == c) xv_e = 1;
          if (rc[j] + 2 <= c) sent_e++;
          if (j >= 8 && rc[j] + 3 == c) yv_e = 1;
        end
        if (c == 0) sent_e = prev_sent;
        x_e = (c > 0 && sent_e > 0) ? ((sent_e - 1 + 10) & 8'hff) : last_x;
        chk("mem_rd", c, mif.mem_rd, int'(rd_j >= 0));
        if (rd_j >= 0) chk("mem_addr", c, mif.mem_addr, rd_j);
        chk("x_valid", c, x_valid, xv_e);
        chk("X", c, X, x_e);
        chk("y_valid", c, y_valid, yv_e);
        chk("sent_cnt", c, sent_cnt, sent_e);
        chk("busy", c, busy, int'(n > 0 && c >= 1 && c < dexp));
        chk("done", c, done, int'(c == dexp));
      end
    end
    start = 1'b0;
    reset = 1'b0;
    if (rst_cyc >= 0) begin
      last_x = 0;
      prev_sent = 0;
    end else begin
      prev_sent = n;
      if (n > 0) last_x = (n - 1 + 10) & 8'hff;
    end
  endtask

  task automatic set_pause(input int lo, input int hi);
    for (int i = 0; i < 4096; i++) pause_pat[i] = (i >= lo && i <= hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout no_finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, nx, ny;
    vecs[0] = '{3, -1, -1, 6, 3, 0};
    vecs[1] = '{12, -1, -1, 15, 12, 4};
    vecs[2] = '{4, 2, 3, 9, 4, 0};
    vecs[3] = '{0, -1, -1, 1, 0, 0};
    vecs[4] = '{1, -1, -1, 4, 1, 0};
    vecs[5] = '{9, -1, -1, 12, 9, 1};
    vecs[6] = '{2, 4, 8, 5, 2, 0};
    vecs[7] = '{3, 0, 0, 6, 3, 0};
    vecs[8] = '{10, 1, 1, 14, 10, 2};

    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    num_samples = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_rd", 0, mif.mem_rd, 0);
    chk("reset_mem_addr", 0, mif.mem_addr, 0);
    chk("reset_x_valid", 0, x_valid, 0);
    chk("reset_y_valid", 0, y_valid, 0);
    chk("reset_busy", 0, busy, 0);
    chk("reset_done", 0, done, 0);
    chk("reset_X", 0, X, 0);
    chk("reset_sent", 0, sent_cnt, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      set_pause(vecs[i].p_lo, vecs[i].p_hi);
      run_xfer(vecs[i].n, -1, -1, dc, nx, ny);
      chk($sformatf("vec%0d_done_cycle", i), 0, dc, vecs[i].exp_done);
      chk($sformatf("vec%0d_x_count", i), 0, nx, vecs[i].exp_nx);
      chk($sformatf("vec%0d_y_count", i), 0, ny, vecs[i].exp_ny);
    end

    // Reset mid-transfer, then a clean short transfer
    set_pause(-1, -1);
    run_xfer(8, 5, -1, dc, nx, ny);
    chk("midrst_done_cycle", 0, dc, -1);
    chk("midrst_x_count", 0, nx, 3);
    run_xfer(2, -1, -1, dc, nx, ny);
    chk("after_rst_done_cycle", 0, dc, 5);
    chk("after_rst_x_count", 0, nx, 2);

    // Second start while busy is ignored
    run_xfer(6, -1, 4, dc, nx, ny);
    chk("restart_done_cycle", 0, dc, 9);
    chk("restart_x_count", 0, nx, 6);

    // Reset wins over start in the same cycle
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    num_samples = (AW+1)'(5);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst_pri_busy", c, busy, 0);
      chk("rst_pri_mem_rd", c, mif.mem_rd, 0);
      chk("rst_pri_done", c, done, 0);
    end
    last_x = 0;
    prev_sent = 0;

    // Full address range without wrap
    set_pause(-1, -1);
    run_xfer(1 << AW, -1, -1, dc, nx, ny);
    chk("full_done_cycle", 0, dc, (1 << AW) + 3);
    chk("full_x_count", 0, nx, 1 << AW);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(0, 30);
      for (int i = 0; i < 4096; i++) pause_pat[i] = ($urandom_range(0, 2) == 0);
      run_xfer(n, -1, -1, dc, nx, ny);
      chk("rand_x_count", r, nx, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_sample_tx.md
CS_SAMPLE_TX -- requirements
Module: cs_sample_tx

Interface
REQ-001 Parameter ADDR_W, default 10, sample-memory address width.
REQ-002 Parameter DATA_W, default 8, sample width, matching the CS input X.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a transfer; sampled only in IDLE.
REQ-006 num_samples  input  ADDR_W+1  sample count N (0..2^ADDR_W); latched when start is accepted.
REQ-007 pause  input  1  while high, no new memory reads are issued.
REQ-008 mem_rd  output  1  sample-memory read strobe.
REQ-009 mem_addr  output  ADDR_W  read address; valid while mem_rd=1.
REQ-010 mem_data  input  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-011 X  output  DATA_W  registered sample to the CS window filter.
REQ-012 x_valid  output  1  X holds a new sample this cycle.
REQ-013 y_valid  output  1  CS output Y reflects a full 9-sample window this cycle.
REQ-014 busy  output  1  transfer in progress.
REQ-015 done  output  1  one-cycle pulse at transfer end.
REQ-016 sent_cnt  output  ADDR_W+1  samples emitted on X since the last accepted start.

Function
REQ-017 FSM states are IDLE, RUN, DRAIN and DONE; busy SHALL be 1 in RUN and DRAIN only.
REQ-018 IDLE: start=1 with N>0 -> RUN; start=1 with N=0 -> DONE with no reads; otherwise stay.
REQ-019 Accepting start SHALL clear rd_cnt, sent_cnt and the window count, and SHALL latch N.
REQ-020 RUN: mem_rd = !pause; each read uses mem_addr = rd_cnt, then rd_cnt increments.
REQ-021 RUN -> DRAIN in the cycle after the read with rd_cnt = N-1 is issued.
REQ-022 The first read SHALL occur in the first cycle after start is sampled.
REQ-023 A read issued in cycle k SHALL produce X = mem_data(k+1) with x_valid=1 in cycle k+2 (two-cycle latency).
REQ-024 Pause SHALL NOT cancel reads already in flight; their samples are still emitted.
REQ-025 When x_valid=0, X SHALL hold its last value.
REQ-026 sent_cnt SHALL increment in each x_valid cycle.
REQ-027 DRAIN: no reads; DRAIN -> DONE once sent_cnt = N.
REQ-028 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-029 The window count SHALL saturate at 9 and increment with each emitted sample.
REQ-030 y_valid SHALL be x_valid delayed by one cycle, and high only when that sample was the 9th or a later sample of the transfer.
REQ-031 start while busy or in DONE SHALL be ignored.
REQ-032 pause SHALL have no effect outside RUN.
REQ-033 With N = 2^ADDR_W, mem_addr SHALL cover 0..2^ADDR_W-1 without wrap, and sent_cnt SHALL reach 2^ADDR_W.

Reset
REQ-034 On reset=1 at a clock edge, the FSM SHALL go to IDLE, and mem_rd, x_valid, y_valid, busy and done SHALL be 0.
REQ-035 On the same reset, X, mem_addr, sent_cnt, rd_cnt and the window count SHALL all be 0.
REQ-036 Reset mid-transfer SHALL discard in-flight mem_data; no x_valid SHALL follow it.
REQ-037 Reset SHALL have priority over start in the same cycle.

Verification
REQ-038 Memory returns addr+10; N=3; start in cycle 0 -> mem_rd in cycles 1-3 (addr 0,1,2); X=10,11,12 with x_valid in cycles 3-5; y_valid never; done in cycle 6; sent_cnt=3.
REQ-039 N=12, no pause -> x_valid in cycles 3-14; y_valid in cycles 12-15 (4 pulses); done in cycle 15.
REQ-040 N=4, pause high in cycles 2-3 -> reads in cycles 1, 4, 5, 6; x_valid in cycles 3, 6, 7, 8; the X sequence stays in address order.
REQ-041 N=0, start -> done in cycle 1; no mem_rd; busy stays 0.
REQ-042 N=8, reset asserted in cycle 5 -> all outputs 0 from cycle 6; no x_valid after reset; a new start with N=2 completes normally.
REQ-043 start pulsed again in cycle 4 of an N=6 transfer -> ignored; exactly 6 samples are sent; done in cycle 9.
